// File: rtl/fibo_bcd_pkg.sv
// Shared definitions for the Fibonacci/BCD engine.
//   state_e          : top-level FSM states (fixed legacy encoding)
//   pow10(d)         : 10**d, usable in constant expressions
//   bcd_nibble_adj() : double-dabble digit correction (>4 then +3)
`timescale 1ns/1ps
package fibo_bcd_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_B2B  = 3'd1,
        S_FIB  = 3'd2,
        S_B2D  = 3'd3,
        S_DONE = 3'd4
    } state_e;

    function automatic longint pow10(input int d);
        longint r;
        r = 1;
        for (int i = 0; i < d; i++) begin
            r = r * 10;
        end
        return r;
    endfunction

    // A digit of 5..9 would exceed 9 after the next doubling; adding 3
    // makes the carry land in the next nibble instead.
    function automatic logic [3:0] bcd_nibble_adj(input logic [3:0] n);
        return (n > 4'd4) ? n + 4'd3 : n;
    endfunction

endpackage

// File: rtl/fibo_bcd_engine_dabble_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one bit per cycle.
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : load bin_in and begin; must only be pulsed when idle
//   bin_in     : FIB_W-bit binary value, must fit in OUT_DIGITS digits
//   done       : high during the FIB_W-th shift cycle after start
//   bcd_next   : BCD value after the current shift; final result when done=1
`timescale 1ns/1ps
module dabble_seq
    import fibo_bcd_pkg::*;
#(
    parameter int FIB_W      = 21,
    parameter int OUT_DIGITS = 6
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [FIB_W-1:0]        bin_in,
    output logic                    done,
    output logic [4*OUT_DIGITS-1:0] bcd_next
);

    localparam int OW    = 4 * OUT_DIGITS;
    localparam int CNT_W = $clog2(FIB_W + 1);

    logic [FIB_W-1:0] bin_q, bin_d;
    logic [OW-1:0]    bcd_q, bcd_d, bcd_adj;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;

    always_comb begin
        for (int i = 0; i < OUT_DIGITS; i++) begin
            bcd_adj[4*i +: 4] = bcd_nibble_adj(bcd_q[4*i +: 4]);
        end
        // Adjust first, then shift in the next binary bit, MSB first.
        bcd_next = {bcd_adj[OW-2:0], bin_q[FIB_W-1]};
        done     = busy_q && (cnt_q == CNT_W'(FIB_W - 1));
    end

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        bin_d  = bin_q;
        bcd_d  = bcd_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        if (start) begin
            bin_d  = bin_in;
            bcd_d  = '0;
            cnt_d  = '0;
            busy_d = 1'b1;
        end else if (busy_q) begin
            bin_d = bin_q << 1;
            bcd_d = bcd_next;
            cnt_d = cnt_q + 1'b1;
            if (done) begin
                busy_d = 1'b0;
            end
        end
    end

    // NOTE: state updates use non-blocking assignments so all flops sample the same pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_q  <= '0;
            bcd_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            bin_q  <= bin_d;
            bcd_q  <= bcd_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
        end
    end

endmodule

// File: rtl/fibo_bcd_engine.sv
// BCD index in, Fibonacci number (or the index itself) out in BCD.
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : request, sampled only while ready=1
//   mode       : 0 = fib(n), 1 = echo n; latched with start
//   bcd_in     : index n, MSD in the top nibble; latched with start
//   ready      : high only when idle
//   done_tick  : one-cycle pulse when bcd_out/overflow/err are valid
//   overflow   : result saturated to all nines
//   err        : an input digit was above 9 (bcd_out forced to 0)
//   bcd_out    : result, MSD in the top nibble; held until next done_tick
`timescale 1ns/1ps
module fibo_bcd_engine
    import fibo_bcd_pkg::*;
#(
    parameter int IN_DIGITS  = 2,
    parameter int OUT_DIGITS = 6,
    parameter int FIB_W      = 21
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    mode,
    input  logic [4*IN_DIGITS-1:0]  bcd_in,
    output logic                    ready,
    output logic                    done_tick,
    output logic                    overflow,
    output logic                    err,
    output logic [4*OUT_DIGITS-1:0] bcd_out
);

    localparam int     IW        = 4 * IN_DIGITS;
    localparam int     OW        = 4 * OUT_DIGITS;
    localparam longint MAX_DEC   = pow10(OUT_DIGITS) - 1;
    localparam int     ACC_W     = $clog2(pow10(IN_DIGITS));
    localparam int     DC_W      = $clog2(IN_DIGITS + 1);
    localparam logic [FIB_W-1:0] MAX_DEC_B = FIB_W'(MAX_DEC);

    // t0+t1 is at most 2*MAX_DEC thanks to the early saturation exit,
    // so that sum must fit in FIB_W bits; the index must fit as well.
    if ((2 * MAX_DEC >= (longint'(1) << FIB_W)) || (ACC_W > FIB_W)) begin : g_bad_fib_w
        $error("fibo_bcd_engine: FIB_W too small for OUT_DIGITS/IN_DIGITS");
    end

    state_e            state_q, state_d;
    logic [IW-1:0]     din_q, din_d;
    logic              mode_q, mode_d;
    logic [DC_W-1:0]   dig_cnt_q, dig_cnt_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [ACC_W-1:0]  cnt_q, cnt_d;
    logic [FIB_W-1:0]  t0_q, t0_d, t1_q, t1_d;
    logic              err_q, err_d;
    logic              ovf_q, ovf_d;
    logic [OW-1:0]     bcd_out_q, bcd_out_d;

    logic [3:0]        digit;
    logic [ACC_W-1:0]  acc_new;
    logic              dab_start;
    logic [FIB_W-1:0]  dab_bin;
    logic              dab_done;
    logic [OW-1:0]     dab_bcd;

    dabble_seq #(
        .FIB_W      (FIB_W),
        .OUT_DIGITS (OUT_DIGITS)
    ) u_dabble (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (dab_start),
        .bin_in   (dab_bin),
        .done     (dab_done),
        .bcd_next (dab_bcd)
    );

    always_comb begin
        state_d   = state_q;
        din_d     = din_q;
        mode_d    = mode_q;
        dig_cnt_d = dig_cnt_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        t0_d      = t0_q;
        t1_d      = t1_q;
        err_d     = err_q;
        ovf_d     = ovf_q;
        bcd_out_d = bcd_out_q;
        dab_start = 1'b0;
        dab_bin   = '0;

        // The latched index shifts left each B2B cycle, so the top nibble
        // is always the next digit to fold in.
        digit   = din_q[IW-1 -: 4];
        acc_new = acc_q * ACC_W'(10) + ACC_W'(digit);

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    din_d     = bcd_in;
                    mode_d    = mode;
                    dig_cnt_d = '0;
                    acc_d     = '0;
                    err_d     = 1'b0;
                    ovf_d     = 1'b0;
                    state_d   = S_B2B;
                end
            end

            S_B2B: begin
                acc_d     = acc_new;
                din_d     = din_q << 4;
                dig_cnt_d = dig_cnt_q + 1'b1;
                err_d     = err_q | (digit > 4'd9);
                if (dig_cnt_q == DC_W'(IN_DIGITS - 1)) begin
                    if (err_d) begin
                        bcd_out_d = '0;
                        state_d   = S_DONE;
                    end else if (mode_q) begin
                        dab_start = 1'b1;
                        dab_bin   = FIB_W'(acc_new);
                        state_d   = S_B2D;
                    end else begin
                        cnt_d   = acc_new;
                        t0_d    = '0;
                        t1_d    = FIB_W'(1);
                        state_d = S_FIB;
                    end
                end
            end

            S_FIB: begin
                if (cnt_q == '0) begin
                    // Only reached for n=0: fib(0) is still in t0.
                    dab_start = 1'b1;
                    dab_bin   = t0_q;
                    state_d   = S_B2D;
                end else if (t1_q > MAX_DEC_B) begin
                    ovf_d     = 1'b1;
                    bcd_out_d = {OUT_DIGITS{4'h9}};
                    state_d   = S_DONE;
                end else begin
                    t0_d  = t1_q;
                    t1_d  = t0_q + t1_q;
                    cnt_d = cnt_q - 1'b1;
                    // On the last step the new t0 (= current t1) is fib(n);
                    // hand it off now to keep FIB occupancy at exactly n cycles.
                    if (cnt_q == ACC_W'(1)) begin
                        dab_start = 1'b1;
                        dab_bin   = t1_q;
                        state_d   = S_B2D;
                    end
                end
            end

            S_B2D: begin
                if (dab_done) begin
                    bcd_out_d = dab_bcd;
                    state_d   = S_DONE;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            din_q     <= '0;
            mode_q    <= 1'b0;
            dig_cnt_q <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            t0_q      <= '0;
            t1_q      <= '0;
            err_q     <= 1'b0;
            ovf_q     <= 1'b0;
            bcd_out_q <= '0;
        end else begin
            state_q   <= state_d;
            din_q     <= din_d;
            mode_q    <= mode_d;
            dig_cnt_q <= dig_cnt_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            t0_q      <= t0_d;
            t1_q      <= t1_d;
            err_q     <= err_d;
            ovf_q     <= ovf_d;
            bcd_out_q <= bcd_out_d;
        end
    end

    assign ready     = (state_q == S_IDLE);
    assign done_tick = (state_q == S_DONE);
    assign overflow  = ovf_q;
    assign err       = err_q;
    assign bcd_out   = bcd_out_q;

endmodule

// File: tb/tb_fibo_bcd_engine.sv
// Self-checking bench for fibo_bcd_engine (default parameters).
// Directed vector table, hand-written multi-cycle sequences, and random
// operations checked against an arithmetic reference model.
`timescale 1ns/1ps
module tb_fibo_bcd_engine;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic        mode = 1'b0;
    logic [7:0]  bcd_in = 8'h00;
    logic        ready, done_tick, overflow, err;
    logic [23:0] bcd_out;

    int n_vec = 0;
    int n_err = 0;

    fibo_bcd_engine #(
        .IN_DIGITS  (2),
        .OUT_DIGITS (6),
        .FIB_W      (21)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .mode      (mode),
        .bcd_in    (bcd_in),
        .ready     (ready),
        .done_tick (done_tick),
        .overflow  (overflow),
        .err       (err),
        .bcd_out   (bcd_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        mode;
        logic [7:0]  bcd;
        logic [23:0] exp_bcd;
        logic        exp_ovf;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    task automatic check(input string name, input longint act, input longint exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference: decimal index, plain Fibonacci recurrence, saturation at
    // the first Fibonacci number above 999999, decimal digits by division.
    task automatic ref_model(input logic m, input logic [7:0] b,
                             output logic [23:0] e_bcd, output logic e_ovf,
                             output logic e_err, output int e_lat);
        int     hi, lo, n;
        longint a, bb, tmp, val;
        hi = int'(b[7:4]);
        lo = int'(b[3:0]);
        e_ovf = 1'b0;
        e_err = 1'b0;
        e_bcd = 24'h0;
        if (hi > 9 || lo > 9) begin
            e_err = 1'b1;
            e_lat = 3;
            return;
        end
        n = hi * 10 + lo;
        if (m) begin
            val   = n;
            e_lat = 2 + 21 + 1;
        end else begin
            a  = 0;
            bb = 1;
            for (int i = 1; i <= n; i++) begin
                tmp = a + bb;
                a   = bb;
                bb  = tmp;
                if (a > 999999) begin
                    e_ovf = 1'b1;
                    e_bcd = 24'h999999;
                    e_lat = 2 + i + 1;
                    return;
                end
            end
            val   = a;
            e_lat = 2 + ((n > 1) ? n : 1) + 21 + 1;
        end
        for (int d = 0; d < 6; d++) begin
            e_bcd[4*d +: 4] = 4'(val % 10);
            val = val / 10;
        end
    endtask

    // Issue one request and wait for done_tick; lat is the cycle number
    // (start-sampling edge = 0) or -1 if the bound expired.
    task automatic run_op(input logic m, input logic [7:0] b,
                          output logic [23:0] g_bcd, output logic g_ovf,
                          output logic g_err, output int lat);
        lat   = -1;
        g_bcd = '0;
        g_ovf = 1'b0;
        g_err = 1'b0;
        @(negedge clk);
        check("ready_before_start", ready, 1);
        start  = 1'b1;
        mode   = m;
        bcd_in = b;
        @(posedge clk);
        for (int c = 1; c <= 200; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (done_tick) begin
                lat   = c;
                g_bcd = bcd_out;
                g_ovf = overflow;
                g_err = err;
                break;
            end
        end
    endtask

    task automatic apply_and_check(input string tag, input logic m, input logic [7:0] b,
                                   input logic [23:0] e_bcd, input logic e_ovf,
                                   input logic e_err, input int e_lat);
        logic [23:0] g_bcd;
        logic        g_ovf, g_err;
        int          lat;
        run_op(m, b, g_bcd, g_ovf, g_err, lat);
        check({tag, "_latency"}, lat, e_lat);
        check({tag, "_bcd_out"}, g_bcd, e_bcd);
        check({tag, "_overflow"}, g_ovf, e_ovf);
        check({tag, "_err"}, g_err, e_err);
    endtask

    initial begin
        vec_t        vecs[11];
        logic [23:0] e_bcd;
        logic        e_ovf, e_err;
        int          e_lat;
        int          ndone, t_first, t_second;
        logic [23:0] b_first, b_second;

        vecs[0]  = '{1'b0, 8'h07, 24'h000013, 1'b0, 1'b0, 31};
        vecs[1]  = '{1'b0, 8'h30, 24'h832040, 1'b0, 1'b0, 54};
        vecs[2]  = '{1'b0, 8'h31, 24'h999999, 1'b1, 1'b0, 34};
        vecs[3]  = '{1'b0, 8'h99, 24'h999999, 1'b1, 1'b0, 34};
        vecs[4]  = '{1'b0, 8'h00, 24'h000000, 1'b0, 1'b0, 25};
        vecs[5]  = '{1'b0, 8'h01, 24'h000001, 1'b0, 1'b0, 25};
        vecs[6]  = '{1'b0, 8'h02, 24'h000001, 1'b0, 1'b0, 26};
        vecs[7]  = '{1'b1, 8'h49, 24'h000049, 1'b0, 1'b0, 24};
        vecs[8]  = '{1'b0, 8'h1A, 24'h000000, 1'b0, 1'b1, 3};
        vecs[9]  = '{1'b1, 8'hA0, 24'h000000, 1'b0, 1'b1, 3};
        vecs[10] = '{1'b0, 8'h12, 24'h000144, 1'b0, 1'b0, 36};

        // Reset values
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_ready", ready, 1);
        check("reset_done_tick", done_tick, 0);
        check("reset_overflow", overflow, 0);
        check("reset_err", err, 0);
        check("reset_bcd_out", bcd_out, 0);
        rst_n = 1'b1;

        // Directed table
        for (int i = 0; i < 11; i++) begin
            apply_and_check($sformatf("vec%0d", i), vecs[i].mode, vecs[i].bcd,
                            vecs[i].exp_bcd, vecs[i].exp_ovf, vecs[i].exp_err,
                            vecs[i].exp_lat);
        end

        // Echo with start pulses while busy: exactly one done_tick
        @(negedge clk);
        start = 1'b1; mode = 1'b1; bcd_in = 8'h49;
        @(posedge clk);
        ndone = 0; t_first = -1; b_first = '0;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            if (done_tick) begin
                ndone++;
                if (t_first < 0) begin
                    t_first = c;
                    b_first = bcd_out;
                end
            end
            start  = !ready && (c % 2 == 1);
            bcd_in = 8'h07;
            mode   = 1'b0;
        end
        start = 1'b0;
        check("busy_start_done_count", ndone, 1);
        check("busy_start_latency", t_first, 24);
        check("busy_start_bcd_out", b_first, 24'h000049);

        // start held high: back-to-back operations
        @(negedge clk);
        start = 1'b1; mode = 1'b0; bcd_in = 8'h05;
        @(posedge clk);
        ndone = 0; t_first = -1; t_second = -1; b_first = '0; b_second = '0;
        for (int c = 1; c <= 120; c++) begin
            @(negedge clk);
            if (done_tick) begin
                ndone++;
                if (ndone == 1) begin
                    t_first = c;
                    b_first = bcd_out;
                end else begin
                    t_second = c;
                    b_second = bcd_out;
                    start    = 1'b0;
                    break;
                end
            end
        end
        start = 1'b0;
        check("held_start_first_latency", t_first, 29);
        check("held_start_second_latency", t_second, 59);
        check("held_start_first_bcd", b_first, 24'h000005);
        check("held_start_second_bcd", b_second, 24'h000005);

        // Reset in the middle of FIB for n=20
        @(negedge clk);
        start = 1'b1; mode = 1'b0; bcd_in = 8'h20;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midreset_ready", ready, 1);
        check("midreset_done_tick", done_tick, 0);
        check("midreset_bcd_out", bcd_out, 0);
        check("midreset_overflow", overflow, 0);
        check("midreset_err", err, 0);
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (done_tick) ndone++;
        end
        check("midreset_no_done_tick", ndone, 0);
        apply_and_check("after_reset_n20", 1'b0, 8'h20, 24'h006765, 1'b0, 1'b0, 44);

        // Random operations against the reference model
        for (int r = 0; r < 40; r++) begin
            logic       m;
            logic [7:0] b;
            m = 1'($urandom_range(0, 1));
            for (int d = 0; d < 2; d++) begin
                if ($urandom_range(0, 7) == 0)
                    b[4*d +: 4] = 4'($urandom_range(10, 15));
                else
                    b[4*d +: 4] = 4'($urandom_range(0, 9));
            end
            ref_model(m, b, e_bcd, e_ovf, e_err, e_lat);
            apply_and_check($sformatf("rand%0d_m%0d_%02h", r, m, b), m, b,
                            e_bcd, e_ovf, e_err, e_lat);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
